// File: rtl/clk_tree_gen.sv
// ---------------------------------------------------------------------------
// clk_tree_gen
//
// Purpose:
//   Generates NCH divided clocks from one system clock. Each channel has a
//   programmable half-period divisor. The output period is 2*max(D,1) cycles
//   with a 50% duty cycle. A new divisor is picked up only at a terminal
//   count, so a half-period is never cut short or stretched. A sync strobe
//   phase-aligns all channels at once.
//
// Optional feature (macro CLKGEN_STEP_EN):
//   Adds single-step logic. The step button passes a 2-flop synchroniser and
//   a rising-edge detector. Each channel runs an FSM (RUN -> FINISH -> HOLD).
//   In HOLD, a step press lets the channel run exactly one full period before
//   it stops again. Without the macro, step_mode and step are ignored and
//   every channel free-runs under ch_en.
//
// Ports:
//   clk        in   system clock, rising edge only
//   rst        in   synchronous active-high reset
//   div_bus    in   NCH*CW; channel i divisor at [i*CW +: CW]
//   ch_en      in   NCH; per-channel run enable
//   sync       in   one-cycle phase-align strobe for all channels
//   step_mode  in   single-step mode select (CLKGEN_STEP_EN only)
//   step       in   raw step button level (CLKGEN_STEP_EN only)
//   div_clk    out  NCH; registered divided clocks
//   tick       out  NCH; one-cycle pulse on each 0->1 of div_clk
//   busy       out  NCH; channel enabled and not held by step logic
// ---------------------------------------------------------------------------
module clk_tree_gen #(
    parameter int NCH = 5,
    parameter int CW  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*CW-1:0] div_bus,
    input  logic [NCH-1:0]    ch_en,
    input  logic              sync,
    input  logic              step_mode,
    input  logic              step,
    output logic [NCH-1:0]    div_clk,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    busy
);

`ifdef CLKGEN_STEP_EN
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FINISH = 2'd1,
        HOLD   = 2'd2
    } step_state_t;

    logic step_meta;
    logic step_sync;
    logic step_prev;
    logic step_pulse;

    // Bring the asynchronous button level into the clock domain and keep
    // one extra stage for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            step_meta <= step;
            step_sync <= step_meta;
            step_prev <= step_sync;
        end
    end

    assign step_pulse = step_sync & ~step_prev;
`else
    logic unused_step;
    assign unused_step = step_mode ^ step;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [CW-1:0] d;
        logic [CW-1:0] last;
        logic [CW-1:0] div_in;
        logic          div_q;
        logic          tick_q;
        logic          at_term;
        logic          hold_now;

        assign div_in = div_bus[i*CW +: CW];

        // D=0 behaves like D=1, so the terminal count is 0 in both cases.
        // Comparing against d-1 keeps D=2^CW-1 well inside the counter range.
        assign last    = (d == '0) ? '0 : d - {{(CW-1){1'b0}}, 1'b1};
        assign at_term = (cnt == last);

        assign div_clk[i] = div_q;
        assign tick[i]    = tick_q;

`ifdef CLKGEN_STEP_EN
        step_state_t state;

        // A channel entering step mode while already idle (low, count 0)
        // parks at once instead of running a spare period.
        assign hold_now = (state == HOLD) ||
                          ((state == RUN) && step_mode && !div_q && (cnt == '0));
        assign busy[i]  = ch_en[i] && (state != HOLD);
`else
        assign hold_now = 1'b0;
        assign busy[i]  = ch_en[i];
`endif

        // Counter, output and step FSM for one channel. Priority is
        // rst > sync > step hold > ch_en > counting. Sync leaves the step
        // state untouched, so a held channel stays held.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt    <= '0;
                d      <= div_in;
                div_q  <= 1'b0;
                tick_q <= 1'b0;
`ifdef CLKGEN_STEP_EN
                state  <= RUN;
`endif
            end else if (sync) begin
                cnt    <= '0;
                d      <= div_in;
                div_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (hold_now) begin
                    cnt   <= '0;
                    div_q <= 1'b0;
                end else if (ch_en[i]) begin
                    if (at_term) begin
                        cnt    <= '0;
                        div_q  <= ~div_q;
                        tick_q <= ~div_q;
                        d      <= div_in;
                    end else begin
                        cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
`ifdef CLKGEN_STEP_EN
                if (!step_mode) begin
                    state <= RUN;
                end else begin
                    case (state)
                        RUN:     state <= hold_now ? HOLD : FINISH;
                        FINISH:  if (ch_en[i] && at_term && div_q) state <= HOLD;
                        HOLD:    if (step_pulse) state <= FINISH;
                        default: state <= RUN;
                    endcase
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_clk_tree_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_tree_gen
//
// Purpose:
//   Self-checking bench for clk_tree_gen (NCH=5, CW=8). Before each clock
//   edge, a stimulus process drives the inputs. It advances a behavioural
//   model that tracks the remaining cycles of each half-period and the
//   output level, then queues the expected outputs. A separate monitor pops
//   one entry after every clock edge and compares div_clk, tick and busy.
//   When CLKGEN_STEP_EN is defined, the model also follows the single-step
//   rules. Otherwise it ignores step_mode and step.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_clk_tree_gen;
    localparam int NCH = 5;
    localparam int CW  = 8;

`ifdef CLKGEN_STEP_EN
    localparam bit USE_STEP = 1'b1;
`else
    localparam bit USE_STEP = 1'b0;
`endif

    localparam int M_RUN    = 0;
    localparam int M_FINISH = 1;
    localparam int M_HOLD   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sync = 1'b0;
    logic              step_mode = 1'b0;
    logic              step = 1'b0;
    logic [NCH*CW-1:0] div_bus = '0;
    logic [NCH-1:0]    ch_en = '1;
    logic [NCH-1:0]    div_clk;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    busy;

    clk_tree_gen #(.NCH(NCH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .div_bus   (div_bus),
        .ch_en     (ch_en),
        .sync      (sync),
        .step_mode (step_mode),
        .step      (step),
        .div_clk   (div_clk),
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] dclk;
        logic [NCH-1:0] tck;
        logic [NCH-1:0] bsy;
    } resp_t;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Reference model: level and remaining cycles of each half-period.
    logic   m_level[NCH];
    logic   m_tick[NCH];
    longint m_left[NCH];
    longint m_half[NCH];
    int     m_mode[NCH];
    logic   h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    // Stimulus shadow registers
    logic [NCH*CW-1:0] bus_v = '0;
    logic [NCH-1:0]    en_v  = '1;
    logic              sm_v  = 1'b0;
    logic              st_v  = 1'b0;

    function automatic longint eff_of(input int i);
        longint v;
        v = longint'(div_bus[i*CW +: CW]);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic void model_edge();
        logic   pulse;
        logic   held;
        logic   fell;
        longint e;
        pulse = h2 & ~h3;
        for (int i = 0; i < NCH; i++) begin
            e = eff_of(i);
            if (rst) begin
                m_level[i] = 1'b0;
                m_tick[i]  = 1'b0;
                m_half[i]  = e;
                m_left[i]  = e;
                m_mode[i]  = M_RUN;
            end else if (sync) begin
                m_level[i] = 1'b0;
                m_tick[i]  = 1'b0;
                m_half[i]  = e;
                m_left[i]  = e;
            end else begin
                m_tick[i] = 1'b0;
                fell = 1'b0;
                held = USE_STEP && ((m_mode[i] == M_HOLD) ||
                       ((m_mode[i] == M_RUN) && step_mode && !m_level[i] &&
                        (m_left[i] == m_half[i])));
                if (!held && ch_en[i]) begin
                    if (m_left[i] == 1) begin
                        m_level[i] = !m_level[i];
                        m_tick[i]  = m_level[i];
                        fell       = !m_level[i];
                        m_half[i]  = e;
                        m_left[i]  = e;
                    end else begin
                        m_left[i] = m_left[i] - 1;
                    end
                end
                if (USE_STEP) begin
                    if (!step_mode)                          m_mode[i] = M_RUN;
                    else if (m_mode[i] == M_RUN)             m_mode[i] = held ? M_HOLD : M_FINISH;
                    else if (m_mode[i] == M_FINISH && fell)  m_mode[i] = M_HOLD;
                    else if (m_mode[i] == M_HOLD && pulse)   m_mode[i] = M_FINISH;
                end
            end
        end
        if (rst) begin
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            h3 = h2; h2 = h1; h1 = step;
        end
    endfunction

    task automatic apply_stimulus(input logic r, input logic s);
        resp_t e;
        @(negedge clk);
        rst       = r;
        sync      = s;
        ch_en     = en_v;
        div_bus   = bus_v;
        step_mode = sm_v;
        step      = st_v;
        model_edge();
        for (int i = 0; i < NCH; i++) begin
            e.dclk[i] = m_level[i];
            e.tck[i]  = m_tick[i];
            e.bsy[i]  = ch_en[i] && (m_mode[i] != M_HOLD);
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0);
    endtask

    task automatic set_div(input int i, input int v);
        bus_v[i*CW +: CW] = CW'(v);
    endtask

    task automatic check_output(input string name, input logic [NCH-1:0] act,
                                input logic [NCH-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    endtask

    // Monitor: one expected entry per clock edge, compared just after it.
    initial begin
        resp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("div_clk", div_clk, e.dclk);
                check_output("tick", tick, e.tck);
                check_output("busy", busy, e.bsy);
            end
        end
    end

    initial begin
        #200000;
        n_checks++;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        // Reset with D={3,6,1,3,3}, all channels enabled
        set_div(0, 3); set_div(1, 6); set_div(2, 1); set_div(3, 3); set_div(4, 3);
        en_v = '1;
        repeat (3) apply_stimulus(1'b1, 1'b0);
        run(32);

        // Divisor change in the middle of a half-period
        run(1);
        set_div(0, 5);
        run(30);

        // Freeze channel 1 for four cycles
        en_v[1] = 1'b0;
        run(4);
        en_v[1] = 1'b1;
        run(30);

        // Phase-align strobe
        set_div(0, 3);
        run(5);
        apply_stimulus(1'b0, 1'b1);
        run(30);

        // One-cycle reset in the middle of a period with D=0 on channel 2
        set_div(2, 0);
        run(5);
        apply_stimulus(1'b1, 1'b0);
        run(12);

        // Step-mode sequence: three presses (free-runs without the macro)
        sm_v = 1'b1;
        run(40);
        for (int p = 0; p < 3; p++) begin
            st_v = 1'b1;
            run(5);
            st_v = 1'b0;
            run(60);
        end
        sm_v = 1'b0;
        run(20);

        // Largest divisor on channel 3
        set_div(3, 255);
        apply_stimulus(1'b0, 1'b1);
        run(1100);

        // Randomised traffic
        set_div(3, 4);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0)
                set_div(int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 9)));
            if ($urandom_range(0, 9) == 0)
                en_v[$urandom_range(0, NCH-1)] ^= 1'b1;
            if (!USE_STEP) begin
                sm_v = 1'($urandom_range(0, 1));
                st_v = 1'($urandom_range(0, 1));
            end
            apply_stimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0));
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("[TB] FAIL queue_drain actual=%0d required=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
